// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch stage: data width, the reset
// instruction (addi x0,x0,0), the PC alignment mask and the fetch FSM states.
// No ports (package).
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int               XLEN       = 32;
    localparam logic [XLEN-1:0]  NOP_INSTR  = 32'h0000_0013;
    localparam logic [1:0]       ALIGN_MASK = 2'b11;

    // IDLE  : one cycle after reset release, no request
    // REQ   : request presented for the current pc
    // WAIT  : one request outstanding, waiting for its response
    // DRAIN : request outstanding but redirected; its response is dropped
    // HOLD  : instruction held until decode accepts it
    // ERR   : misaligned pc seen; waiting for a redirect
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_HOLD  = 3'd4,
        ST_ERR   = 3'd5
    } fetch_state_t;

    // Word alignment test on the low address bits.
    function automatic logic is_aligned(input logic [1:0] lsb);
        return (lsb & ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Fetch stage between the PC register and decode. Presents pc to instruction
// memory over a valid/ready request channel, keeps exactly one request in
// flight, holds the returned word (with its pc) until decode accepts it, and
// generates the single-cycle pc_en strobe for the PC register. Handles
// redirects (flush) and misaligned pc values (sticky misaligned_err).
//
// Ports
//   clk             in   rising-edge clock
//   rst             in   asynchronous reset, active low
//   pc              in   current PC from the PC register
//   pc_en           out  PC register loads its next value at this edge
//   flush           in   redirect; PC source selects the target this cycle
//   imem_req_valid  out  fetch request valid
//   imem_req_ready  in   memory accepts the request
//   imem_req_addr   out  fetch address
//   imem_rsp_valid  in   response data valid
//   imem_rsp_data   in   fetched word
//   instr           out  held instruction (NOP_INSTR after reset)
//   instr_pc        out  PC of instr
//   instr_valid     out  instr is valid
//   instr_ready     in   decode consumes instr
//   misaligned_err  out  sticky: pc[1:0] != 0 at request time
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter int              XLEN      = fetch_pkg::XLEN,
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(fetch_pkg::NOP_INSTR)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc,
    output logic            pc_en,
    input  logic            flush,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic            misaligned_err
);
    import fetch_pkg::*;

    fetch_state_t    r_state;
    fetch_state_t    w_next;

    logic [XLEN-1:0] r_req_pc;
    logic [XLEN-1:0] r_instr;
    logic [XLEN-1:0] r_instr_pc;
    logic            r_instr_valid;
    logic            r_mis_err;

    logic            w_aligned;
    logic            w_hs;

    assign w_aligned = is_aligned(pc[1:0]);
    assign w_hs      = imem_req_valid & imem_req_ready;

    // pc only moves on pc_en, so the address is stable while a request stalls.
    assign imem_req_addr  = pc;
    assign instr          = r_instr;
    assign instr_pc       = r_instr_pc;
    assign instr_valid    = r_instr_valid;
    assign misaligned_err = r_mis_err;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next;
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: w_next = ST_REQ;
            ST_REQ: begin
                // The request is withdrawn while flushing, so a handshake can
                // never coincide with a redirect here; stay and re-request at
                // the new pc next cycle.
                if (flush)           w_next = ST_REQ;
                else if (!w_aligned) w_next = ST_ERR;
                else if (w_hs)       w_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (flush && imem_rsp_valid) w_next = ST_REQ;   // response dropped
                else if (flush)              w_next = ST_DRAIN;
                else if (imem_rsp_valid)     w_next = ST_HOLD;
            end
            // The response of the redirected request must still be swallowed
            // before a new request can go out (one in flight at a time).
            ST_DRAIN: if (imem_rsp_valid)        w_next = ST_REQ;
            ST_HOLD:  if (flush || instr_ready)  w_next = ST_REQ;
            ST_ERR:   if (flush)                 w_next = ST_REQ;
            default:                             w_next = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic (combinational strobes)
    // -------------------------------------------------------------------------
    always_comb begin
        pc_en          = 1'b0;
        imem_req_valid = 1'b0;
        case (r_state)
            ST_REQ: begin
                imem_req_valid = ~flush & w_aligned;
                pc_en          = flush;
            end
            ST_WAIT,
            ST_DRAIN,
            ST_ERR:  pc_en = flush;
            ST_HOLD: pc_en = flush | instr_ready;
            default: begin
                pc_en          = 1'b0;
                imem_req_valid = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath registers: request pc, held instruction, error flag
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_req_pc      <= '0;
            r_instr       <= NOP_INSTR;
            r_instr_pc    <= '0;
            r_instr_valid <= 1'b0;
            r_mis_err     <= 1'b0;
        end else begin
            case (r_state)
                ST_REQ: begin
                    if (w_hs) r_req_pc <= pc;
                    if (!flush && !w_aligned) r_mis_err <= 1'b1;
                end
                ST_WAIT: begin
                    if (imem_rsp_valid && !flush) begin
                        r_instr       <= imem_rsp_data;
                        r_instr_pc    <= r_req_pc;
                        r_instr_valid <= 1'b1;
                    end
                end
                // Flush and accept both retire the held word.
                ST_HOLD: if (flush || instr_ready) r_instr_valid <= 1'b0;
                ST_ERR:  if (flush)                r_mis_err     <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
// Self-checking bench for instr_fetch. A PC register model and a memory
// responder surround the DUT; a vector table drives the fetch stream and
// expected words go through a scoreboard queue. Hand-written sequences cover
// flush, misaligned pc and reset-in-flight.
// -----------------------------------------------------------------------------
module tb_instr_fetch;
    import fetch_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] pc;
    logic         pc_en;
    logic         flush = 1'b0;
    logic [W-1:0] tgt = '0;
    logic         req_valid;
    logic         req_ready = 1'b0;
    logic [W-1:0] req_addr;
    logic         rsp_valid = 1'b0;
    logic [W-1:0] rsp_data = '0;
    logic [W-1:0] instr;
    logic [W-1:0] instr_pc;
    logic         instr_valid;
    logic         instr_ready = 1'b0;
    logic         mis_err;

    int errors = 0;
    int checks = 0;
    int rsp_delay = 0;

    logic [W-1:0] mem [logic [W-1:0]];

    typedef struct {
        logic [W-1:0] data;
        logic [W-1:0] pc;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [W-1:0] pc;
        logic [W-1:0] data;
        int           req_stall;
        int           rsp_dly;
        int           acc_stall;
        int           lat;
    } vec_t;

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .pc             (pc),
        .pc_en          (pc_en),
        .flush          (flush),
        .imem_req_valid (req_valid),
        .imem_req_ready (req_ready),
        .imem_req_addr  (req_addr),
        .imem_rsp_valid (rsp_valid),
        .imem_rsp_data  (rsp_data),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .misaligned_err (mis_err)
    );

    // PC register: next sequential pc, or the redirect target on flush.
    always @(posedge clk or negedge rst) begin
        if (!rst)       pc <= '0;
        else if (pc_en) pc <= flush ? tgt : pc + 32'd4;
    end

    function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'hDEAD_0000;
    endfunction

    // Memory responder: answers rsp_delay cycles after the zero-wait slot.
    // Not reset, so a response in flight at reset still shows up later.
    logic         m_pend = 1'b0;
    int           m_cnt = 0;
    logic [W-1:0] m_addr = '0;
    always @(posedge clk) begin
        rsp_valid <= 1'b0;
        if (m_pend) begin
            if (m_cnt == 0) begin
                rsp_valid <= 1'b1;
                rsp_data  <= mem_word(m_addr);
                m_pend    <= 1'b0;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
        if (req_valid && req_ready) begin
            if (rsp_delay == 0) begin
                rsp_valid <= 1'b1;
                rsp_data  <= mem_word(req_addr);
            end else begin
                m_pend <= 1'b1;
                m_cnt  <= rsp_delay - 1;
                m_addr <= req_addr;
            end
        end
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic chk_b(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, want %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a held instruction, compare with the scoreboard
    // head, then accept it. Returns at posedge+1 after the accept edge.
    task automatic expect_fetch(input string name);
        exp_t e;
        bit   got;
        got = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (instr_valid) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        e = sb.pop_front();
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s_timeout: instr_valid stayed 0, want 1", name);
            return;
        end
        chk({name, "_instr"}, instr, e.data);
        chk({name, "_instr_pc"}, instr_pc, e.pc);
        instr_ready = 1'b1;
        #1;
        chk_b({name, "_accept_pc_en"}, pc_en, 1'b1);
        tick();
        instr_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[5];
        int   n;
        int   stall;
        bit   got;
        bit   seen_req;
        exp_t e;

        vecs[0] = '{pc: 32'h0,  data: 32'h0050_0093, req_stall: 0, rsp_dly: 0, acc_stall: 0, lat: 3};
        vecs[1] = '{pc: 32'h4,  data: 32'h00A0_0113, req_stall: 4, rsp_dly: 0, acc_stall: 5, lat: 7};
        vecs[2] = '{pc: 32'h8,  data: 32'h0020_81B3, req_stall: 0, rsp_dly: 0, acc_stall: 0, lat: 3};
        vecs[3] = '{pc: 32'hC,  data: 32'h4020_8233, req_stall: 0, rsp_dly: 2, acc_stall: 1, lat: 5};
        vecs[4] = '{pc: 32'h10, data: 32'h0041_A023, req_stall: 0, rsp_dly: 0, acc_stall: 0, lat: 3};

        // ---- reset with random inputs ----
        rst = 1'b1;
        #2 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            flush       = 1'($urandom_range(0, 1));
            instr_ready = 1'($urandom_range(0, 1));
            req_ready   = 1'($urandom_range(0, 1));
            tgt         = $urandom;
            @(negedge clk);
            chk("rst_instr", instr, NOP_INSTR);
            chk("rst_instr_pc", instr_pc, 32'h0);
            chk_b("rst_instr_valid", instr_valid, 1'b0);
            chk_b("rst_mis_err", mis_err, 1'b0);
            chk_b("rst_req_valid", req_valid, 1'b0);
            chk_b("rst_pc_en", pc_en, 1'b0);
            tick();
        end

        // Release with flush high: IDLE ignores it, pc stays 0.
        instr_ready = 1'b0;
        req_ready   = 1'b0;
        flush       = 1'b1;
        tgt         = 32'h0000_0F00;
        rst         = 1'b1;
        @(negedge clk);
        chk_b("idle_req_valid", req_valid, 1'b0);
        chk_b("idle_pc_en", pc_en, 1'b0);
        tick();
        flush = 1'b0;

        // ---- table-driven fetch stream ----
        foreach (vecs[r]) begin
            mem[vecs[r].pc] = vecs[r].data;
            sb.push_back('{data: vecs[r].data, pc: vecs[r].pc});
            rsp_delay   = vecs[r].rsp_dly;
            req_ready   = (vecs[r].req_stall == 0);
            instr_ready = 1'b0;
            n = 1; stall = 0; got = 1'b0; seen_req = 1'b0;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                if (instr_valid) begin
                    got = 1'b1;
                    break;
                end
                chk_b("stream_pc_en_quiet", pc_en, 1'b0);
                if (req_valid && !seen_req) begin
                    seen_req = 1'b1;
                    chk("stream_req_addr", req_addr, vecs[r].pc);
                end
                if (req_valid && !req_ready) begin
                    stall++;
                    chk("stall_req_addr", req_addr, vecs[r].pc);
                end
                tick();
                n++;
                if (stall == vecs[r].req_stall) req_ready = 1'b1;
            end
            e = sb.pop_front();
            checks++;
            if (!got) begin
                errors++;
                $display("FAIL stream_timeout row %0d: instr_valid stayed 0, want 1", r);
            end else begin
                chk("stream_instr", instr, e.data);
                chk("stream_instr_pc", instr_pc, e.pc);
                chk("stream_latency", n, vecs[r].lat);
                for (int k = 0; k < vecs[r].acc_stall; k++) begin
                    tick();
                    @(negedge clk);
                    chk_b("hold_valid", instr_valid, 1'b1);
                    chk("hold_instr", instr, e.data);
                    chk("hold_instr_pc", instr_pc, e.pc);
                    chk_b("hold_pc_en", pc_en, 1'b0);
                end
                instr_ready = 1'b1;
                #1;
                chk_b("accept_pc_en", pc_en, 1'b1);
                tick();
                instr_ready = 1'b0;
            end
        end

        // ---- flush in WAIT, response 2 cycles later, target 0x100 ----
        req_ready = 1'b1;
        rsp_delay = 2;
        @(negedge clk);
        chk_b("fw_req_valid", req_valid, 1'b1);
        chk("fw_req_addr", req_addr, 32'h14);
        tick();                                   // handshake -> WAIT
        flush = 1'b1;
        tgt   = 32'h100;
        @(negedge clk);
        chk_b("fw_pc_en", pc_en, 1'b1);
        tick();                                   // -> DRAIN
        flush = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (req_valid) begin
                got = 1'b1;
                break;
            end
            chk_b("fw_drain_pc_en", pc_en, 1'b0);
            chk_b("fw_drain_valid", instr_valid, 1'b0);
            tick();
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL fw_timeout: no request after drain, want one");
        end
        chk("fw_new_addr", req_addr, 32'h100);
        chk("fw_no_stale", instr, 32'h0041_A023);
        chk_b("fw_valid_low", instr_valid, 1'b0);
        rsp_delay = 0;
        sb.push_back('{data: 32'hDEAD_0100, pc: 32'h100});
        expect_fetch("fw_refetch");

        // ---- flush in the same cycle as the response ----
        req_ready = 1'b1;
        rsp_delay = 1;
        tick();                                   // handshake at 0x104 -> WAIT
        tick();                                   // response visible this cycle
        flush     = 1'b1;
        tgt       = 32'h180;
        req_ready = 1'b0;
        @(negedge clk);
        chk_b("sf_pc_en", pc_en, 1'b1);
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk_b("sf_req_valid", req_valid, 1'b1);
        chk("sf_req_addr", req_addr, 32'h180);
        chk_b("sf_valid_low", instr_valid, 1'b0);
        chk("sf_instr_kept", instr, 32'hDEAD_0100);
        tick();
        @(negedge clk);
        chk_b("sf_still_req", req_valid, 1'b1);
        chk_b("sf_pc_en_low", pc_en, 1'b0);

        // ---- misaligned pc 0x102, then redirect to 0x200 ----
        tick();
        flush = 1'b1;
        tgt   = 32'h102;
        @(negedge clk);
        chk_b("ma_flush_pc_en", pc_en, 1'b1);
        chk_b("ma_flush_req_off", req_valid, 1'b0);
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk_b("ma_no_req", req_valid, 1'b0);
        chk_b("ma_pc_en", pc_en, 1'b0);
        tick();
        req_ready = 1'b1;
        @(negedge clk);
        chk_b("ma_err_set", mis_err, 1'b1);
        chk_b("ma_err_no_req", req_valid, 1'b0);
        tick();
        @(negedge clk);
        chk_b("ma_err_sticky", mis_err, 1'b1);
        chk_b("ma_err_pc_en", pc_en, 1'b0);
        tick();
        flush = 1'b1;
        tgt   = 32'h200;
        @(negedge clk);
        chk_b("ma_clear_pc_en", pc_en, 1'b1);
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk_b("ma_err_cleared", mis_err, 1'b0);
        chk_b("ma_req_valid", req_valid, 1'b1);
        chk("ma_req_addr", req_addr, 32'h200);

        // ---- reset during WAIT; the late response must be ignored ----
        rsp_delay = 3;
        tick();                                   // handshake at 0x200 -> WAIT
        rst = 1'b0;
        #1;
        chk("wr_instr", instr, NOP_INSTR);
        chk("wr_instr_pc", instr_pc, 32'h0);
        chk_b("wr_instr_valid", instr_valid, 1'b0);
        chk_b("wr_req_valid", req_valid, 1'b0);
        chk_b("wr_pc_en", pc_en, 1'b0);
        chk_b("wr_mis_err", mis_err, 1'b0);
        tick();
        tick();
        rst       = 1'b1;
        req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_b("wr_late_valid", instr_valid, 1'b0);
            chk("wr_late_instr", instr, NOP_INSTR);
            tick();
        end
        rsp_delay = 0;
        req_ready = 1'b1;
        sb.push_back('{data: 32'h0050_0093, pc: 32'h0});
        expect_fetch("wr_refetch");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
